// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game controller: state encoding
// (identical to the overlay text_sel code), refresh position and BCD helpers.
package pong_pkg;

   typedef enum logic [1:0] {
      ST_NEWGAME = 2'd0,
      ST_PLAY    = 2'd1,
      ST_NEWBALL = 2'd2,
      ST_OVER    = 2'd3
   } state_e;

   // One refresh tick per frame, just after the last visible line.
   localparam logic [9:0] REFR_Y = 10'd481;
   localparam logic [9:0] REFR_X = 10'd0;

   typedef logic [3:0] bcd_t;

   // Two-digit BCD increment that sticks at 99 instead of rolling over.
   function automatic logic [7:0] bcd_inc_sat(input bcd_t d1, input bcd_t d0);
      logic [7:0] r;
      r = {d1, d0};
      if (d1 == 4'd9 && d0 == 4'd9)
         r = {d1, d0};
      else if (d0 == 4'd9)
         r = {d1 + 4'd1, 4'd0};
      else
         r = {d1, d0 + 4'd1};
      return r;
   endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the game controller and the scan/graphics/overlay side.
interface pong_game_ctrl_if;
   import pong_pkg::*;

   logic [9:0] pix_x;
   logic [9:0] pix_y;
   logic [3:0] btn;
   logic       hit;
   logic       miss;
   logic       gra_still;
   bcd_t       score_d1;
   bcd_t       score_d0;
   logic [1:0] balls_left;
   logic [1:0] text_sel;

   modport master (
      input  pix_x, pix_y, btn, hit, miss,
      output gra_still, score_d1, score_d0, balls_left, text_sel
   );

   modport slave (
      output pix_x, pix_y, btn, hit, miss,
      input  gra_still, score_d1, score_d0, balls_left, text_sel
   );

endinterface

// File: rtl/pong_timer.sv
// Frame-based delay: load to WAIT_FRAMES, count down once per refresh tick,
// park at zero. done is a decode of the count register.
module pong_timer #(
   parameter int WAIT_FRAMES = 120
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic tick,
   output logic done
);

   localparam int CW = $clog2(WAIT_FRAMES + 1);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load)
         count_d = CW'(WAIT_FRAMES);
      else if (tick && count_q != '0)
         count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign done = (count_q == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Game-level sequencer for pong: new game / play / serve / game over, with
// hit edge detection, saturating BCD score and remaining-ball count.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int BALLS       = 3,
   parameter int WAIT_FRAMES = 120
) (
   input  logic             clk,
   input  logic             reset,
   pong_game_ctrl_if.master io
);

   localparam logic [1:0] BALLS_INIT = 2'(BALLS);

   state_e     state_q, state_d;
   bcd_t       d1_q, d1_d;
   bcd_t       d0_q, d0_d;
   logic [1:0] balls_q, balls_d;
   logic       hit_d_q;

   logic       refr_tick;
   logic       hit_edge;
   logic       btn_any;
   logic       timer_load;
   logic       timer_done;

   assign refr_tick = (io.pix_y == REFR_Y) && (io.pix_x == REFR_X);
   // hit is a whole-frame level; only its rising edge scores.
   assign hit_edge  = io.hit & ~hit_d_q;
   assign btn_any   = |io.btn;

   pong_timer #(.WAIT_FRAMES(WAIT_FRAMES)) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (timer_load),
      .tick  (refr_tick),
      .done  (timer_done)
   );

   always_comb begin
      state_d    = state_q;
      d1_d       = d1_q;
      d0_d       = d0_q;
      balls_d    = balls_q;
      timer_load = 1'b0;
      case (state_q)
         ST_NEWGAME: begin
            if (btn_any) begin
               d1_d    = 4'd0;
               d0_d    = 4'd0;
               balls_d = BALLS_INIT;
               state_d = ST_PLAY;
            end
         end
         ST_PLAY: begin
            // A miss takes priority; a coincident hit edge is dropped.
            if (io.miss) begin
               timer_load = 1'b1;
               if (balls_q == 2'd1) begin
                  balls_d = 2'd0;
                  state_d = ST_OVER;
               end else begin
                  balls_d = balls_q - 2'd1;
                  state_d = ST_NEWBALL;
               end
            end else if (hit_edge) begin
               {d1_d, d0_d} = bcd_inc_sat(d1_q, d0_q);
            end
         end
         ST_NEWBALL: begin
            if (timer_done && btn_any)
               state_d = ST_PLAY;
         end
         ST_OVER: begin
            if (timer_done)
               state_d = ST_NEWGAME;
         end
         default: state_d = ST_NEWGAME;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_NEWGAME;
         d1_q    <= 4'd0;
         d0_q    <= 4'd0;
         balls_q <= BALLS_INIT;
         hit_d_q <= 1'b0;
      end else begin
         state_q <= state_d;
         d1_q    <= d1_d;
         d0_q    <= d0_d;
         balls_q <= balls_d;
         hit_d_q <= io.hit;
      end
   end

   assign io.gra_still  = (state_q != ST_PLAY);
   assign io.text_sel   = state_q;
   assign io.score_d1   = d1_q;
   assign io.score_d0   = d0_q;
   assign io.balls_left = balls_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: frames are compressed to four clocks,
// one of which carries the refresh scan position.
module tb_pong_game_ctrl;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   pong_game_ctrl_if bus ();

   pong_game_ctrl #(.BALLS(3), .WAIT_FRAMES(120)) dut (
      .clk   (clk),
      .reset (reset),
      .io    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // status = {text_sel, gra_still, balls_left, score_d1, score_d0}
   logic [12:0] status;
   assign status = {bus.text_sel, bus.gra_still, bus.balls_left, bus.score_d1, bus.score_d0};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic frames(input int n);
      for (int f = 0; f < n; f++) begin
         bus.pix_y = 10'd481; bus.pix_x = 10'd0;
         step();
         bus.pix_y = 10'd0;
         step(); step(); step();
      end
   endtask

   task automatic hit_pulse();
      bus.hit = 1'b1; step();
      bus.hit = 1'b0; step();
   endtask

   // Hold btn across a full serve delay, ending in PLAY.
   task automatic serve();
      bus.btn = 4'b0100;
      frames(121);
      bus.btn = 4'b0000;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(); step();
      checks++;
      if (status !== {2'd0, 1'b1, 2'd3, 4'd0, 4'd0}) begin
         errors++; $display("FAIL reset_state: got %h expected %h", status, {2'd0, 1'b1, 2'd3, 4'd0, 4'd0});
      end
      reset = 1'b0;
      step();
      checks++;
      if (status !== {2'd0, 1'b1, 2'd3, 4'd0, 4'd0}) begin
         errors++; $display("FAIL idle_newgame: got %h expected %h", status, {2'd0, 1'b1, 2'd3, 4'd0, 4'd0});
      end
   endtask

   task automatic test_start();
      bus.btn = 4'b0001; step();
      bus.btn = 4'b0000;
      checks++;
      if (status !== {2'd1, 1'b0, 2'd3, 4'd0, 4'd0}) begin
         errors++; $display("FAIL start_play: got %h expected %h", status, {2'd1, 1'b0, 2'd3, 4'd0, 4'd0});
      end
      bus.btn = 4'b1000; step();
      bus.btn = 4'b0000;
      checks++;
      if (status !== {2'd1, 1'b0, 2'd3, 4'd0, 4'd0}) begin
         errors++; $display("FAIL btn_in_play: got %h expected %h", status, {2'd1, 1'b0, 2'd3, 4'd0, 4'd0});
      end
   endtask

   task automatic test_hit_count();
      for (int h = 1; h <= 12; h++) begin
         bus.hit = 1'b1; frames(3);
         bus.hit = 1'b0; frames(1);
         if (h == 1) begin
            checks++;
            if ({bus.score_d1, bus.score_d0} !== 8'h01) begin
               errors++; $display("FAIL held_hit_once: got %h expected 01", {bus.score_d1, bus.score_d0});
            end
         end
         if (h == 10) begin
            checks++;
            if ({bus.score_d1, bus.score_d0} !== 8'h10) begin
               errors++; $display("FAIL units_carry: got %h expected 10", {bus.score_d1, bus.score_d0});
            end
         end
      end
      checks++;
      if ({bus.score_d1, bus.score_d0} !== 8'h12) begin
         errors++; $display("FAIL score_12: got %h expected 12", {bus.score_d1, bus.score_d0});
      end
   endtask

   task automatic test_saturation();
      for (int h = 0; h < 86; h++) hit_pulse();
      checks++;
      if ({bus.score_d1, bus.score_d0} !== 8'h98) begin
         errors++; $display("FAIL score_98: got %h expected 98", {bus.score_d1, bus.score_d0});
      end
      for (int h = 0; h < 3; h++) hit_pulse();
      checks++;
      if ({bus.score_d1, bus.score_d0} !== 8'h99) begin
         errors++; $display("FAIL score_sat: got %h expected 99", {bus.score_d1, bus.score_d0});
      end
   endtask

   task automatic test_serve();
      bus.miss = 1'b1; bus.btn = 4'b0010; step();
      bus.miss = 1'b0;
      checks++;
      if (status !== {2'd2, 1'b1, 2'd2, 4'd9, 4'd9}) begin
         errors++; $display("FAIL miss_newball: got %h expected %h", status, {2'd2, 1'b1, 2'd2, 4'd9, 4'd9});
      end
      frames(119);
      checks++;
      if (bus.text_sel !== 2'd2) begin
         errors++; $display("FAIL serve_early_119: got %0d expected 2", bus.text_sel);
      end
      // 120th tick brings the count to zero; PLAY follows on the next edge.
      bus.pix_y = 10'd481; bus.pix_x = 10'd0; step();
      bus.pix_y = 10'd0;
      checks++;
      if (bus.text_sel !== 2'd2) begin
         errors++; $display("FAIL serve_at_zero: got %0d expected 2", bus.text_sel);
      end
      step();
      checks++;
      if (status !== {2'd1, 1'b0, 2'd2, 4'd9, 4'd9}) begin
         errors++; $display("FAIL serve_play: got %h expected %h", status, {2'd1, 1'b0, 2'd2, 4'd9, 4'd9});
      end
      bus.btn = 4'b0000;
   endtask

   task automatic test_game_over();
      bus.miss = 1'b1; step();
      bus.miss = 1'b0;
      checks++;
      if (status !== {2'd2, 1'b1, 2'd1, 4'd9, 4'd9}) begin
         errors++; $display("FAIL second_miss: got %h expected %h", status, {2'd2, 1'b1, 2'd1, 4'd9, 4'd9});
      end
      serve();
      bus.miss = 1'b1; step();
      bus.miss = 1'b0;
      checks++;
      if (status !== {2'd3, 1'b1, 2'd0, 4'd9, 4'd9}) begin
         errors++; $display("FAIL game_over: got %h expected %h", status, {2'd3, 1'b1, 2'd0, 4'd9, 4'd9});
      end
      frames(119);
      bus.pix_y = 10'd481; bus.pix_x = 10'd0; step();
      bus.pix_y = 10'd0;
      checks++;
      if (bus.text_sel !== 2'd3) begin
         errors++; $display("FAIL over_hold: got %0d expected 3", bus.text_sel);
      end
      step();
      checks++;
      if (status !== {2'd0, 1'b1, 2'd0, 4'd9, 4'd9}) begin
         errors++; $display("FAIL over_newgame: got %h expected %h", status, {2'd0, 1'b1, 2'd0, 4'd9, 4'd9});
      end
      bus.btn = 4'b0001; step();
      bus.btn = 4'b0000;
      checks++;
      if (status !== {2'd1, 1'b0, 2'd3, 4'd0, 4'd0}) begin
         errors++; $display("FAIL restart_clear: got %h expected %h", status, {2'd1, 1'b0, 2'd3, 4'd0, 4'd0});
      end
   endtask

   task automatic test_simultaneous();
      hit_pulse();
      checks++;
      if ({bus.score_d1, bus.score_d0} !== 8'h01) begin
         errors++; $display("FAIL pre_sim_hit: got %h expected 01", {bus.score_d1, bus.score_d0});
      end
      bus.hit = 1'b1; bus.miss = 1'b1; step();
      bus.hit = 1'b0; bus.miss = 1'b0;
      checks++;
      if (status !== {2'd2, 1'b1, 2'd2, 4'd0, 4'd1}) begin
         errors++; $display("FAIL hit_miss_same: got %h expected %h", status, {2'd2, 1'b1, 2'd2, 4'd0, 4'd1});
      end
   endtask

   task automatic test_reset_mid();
      bus.btn = 4'b0001;
      frames(10);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (status !== {2'd0, 1'b1, 2'd3, 4'd0, 4'd0}) begin
         errors++; $display("FAIL async_reset: got %h expected %h", status, {2'd0, 1'b1, 2'd3, 4'd0, 4'd0});
      end
      bus.btn = 4'b0000;
      step();
      reset = 1'b0;
      step();
      // Timer was cleared, so a fresh game starts on the press.
      bus.btn = 4'b0001; step();
      bus.btn = 4'b0000;
      checks++;
      if (status !== {2'd1, 1'b0, 2'd3, 4'd0, 4'd0}) begin
         errors++; $display("FAIL post_reset_start: got %h expected %h", status, {2'd1, 1'b0, 2'd3, 4'd0, 4'd0});
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b1;
      bus.pix_x = 10'd0;
      bus.pix_y = 10'd0;
      bus.btn  = 4'b0000;
      bus.hit  = 1'b0;
      bus.miss = 1'b0;
      test_reset();
      test_start();
      test_hit_count();
      test_saturation();
      test_serve();
      test_game_over();
      test_simultaneous();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
